// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
// Holds the frame FSM state encoding, the parity selectors and the data-width limits.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  localparam int DATA_W_MIN = 5;
  localparam int DATA_W_MAX = 8;

  // Narrower data words are zero-extended by the caller, which leaves the XOR unchanged.
  function automatic logic parity_bit(input logic [DATA_W_MAX-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period generator: a down-counter that reloads from div and flags each bit boundary.
// A restart pulse realigns the period so the first bit of a frame is full length.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  input  logic [DIV_W-1:0] div,
  output logic             bit_tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  // Next count: load on restart or on reaching zero, otherwise count down.
  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = div;
    end else if (cnt_q == {DIV_W{1'b0}}) begin
      cnt_d = div;
    end else begin
      cnt_d = cnt_q - {{(DIV_W-1){1'b0}}, 1'b1};
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= {DIV_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_tick = (cnt_q == {DIV_W{1'b0}});

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start bit, DATA_W data bits LSB first, optional parity,
// and one or two stop bits, with a valid/ready byte handshake and a programmable bit period.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic              parity_en,
  input  logic              parity_odd,
  input  logic              stop_bit,
  output logic              tx_out,
  output logic              busy,
  output logic              tx_done
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              par_q, par_d;
  logic              par_en_q, par_en_d;
  logic              stop2_q, stop2_d;
  logic              tx_out_q, tx_out_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              hs_s;
  logic              bit_tick_s;
  logic [DIV_W-1:0]  div_sel_s;

  assign tx_ready  = (state_q == IDLE);
  assign hs_s      = tx_valid & tx_ready;
  // The handshake cycle must load the divisor that is being latched, not the old frame's.
  assign div_sel_s = hs_s ? baud_div : div_q;

  uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
    .clk      (clk),
    .reset    (reset),
    .restart  (hs_s),
    .div      (div_sel_s),
    .bit_tick (bit_tick_s)
  );

  // Frame sequencing: tx_out_d is the level of the bit period that starts on the next edge.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    div_d     = div_q;
    par_d     = par_q;
    par_en_d  = par_en_q;
    stop2_d   = stop2_q;
    tx_out_d  = tx_out_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (hs_s) begin
          state_d   = START;
          shift_d   = tx_data;
          bit_cnt_d = {CNT_W{1'b0}};
          div_d     = baud_div;
          par_d     = parity_bit(DATA_W_MAX'(tx_data), parity_odd);
          par_en_d  = parity_en;
          stop2_d   = stop_bit;
          tx_out_d  = 1'b0;
          busy_d    = 1'b1;
        end else begin
          tx_out_d  = 1'b1;
          busy_d    = 1'b0;
        end
      end
      START: begin
        if (bit_tick_s) begin
          state_d   = DATA;
          tx_out_d  = shift_q[0];
          shift_d   = {1'b0, shift_q[DATA_W-1:1]};
          bit_cnt_d = CNT_ONE;
        end else begin
          state_d   = START;
        end
      end
      DATA: begin
        if (bit_tick_s) begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = {CNT_W{1'b0}};
            if (par_en_q) begin
              state_d  = PARITY;
              tx_out_d = par_q;
            end else begin
              state_d  = STOP;
              tx_out_d = 1'b1;
            end
          end else begin
            tx_out_d  = shift_q[0];
            shift_d   = {1'b0, shift_q[DATA_W-1:1]};
            bit_cnt_d = bit_cnt_q + CNT_ONE;
          end
        end else begin
          state_d = DATA;
        end
      end
      PARITY: begin
        if (bit_tick_s) begin
          state_d   = STOP;
          tx_out_d  = 1'b1;
          bit_cnt_d = {CNT_W{1'b0}};
        end else begin
          state_d   = PARITY;
        end
      end
      STOP: begin
        if (bit_tick_s) begin
          if (bit_cnt_q == {{(CNT_W-1){1'b0}}, stop2_q}) begin
            state_d  = IDLE;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            tx_out_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_ONE;
          end
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d  = IDLE;
        tx_out_d = 1'b1;
        busy_d   = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial frame without a done pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      shift_q   <= {DATA_W{1'b0}};
      bit_cnt_q <= {CNT_W{1'b0}};
      div_q     <= {DIV_W{1'b0}};
      par_q     <= 1'b0;
      par_en_q  <= 1'b0;
      stop2_q   <= 1'b0;
      tx_out_q  <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      div_q     <= div_d;
      par_q     <= par_d;
      par_en_q  <= par_en_d;
      stop2_q   <= stop2_d;
      tx_out_q  <= tx_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign tx_out  = tx_out_q;
  assign busy    = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: 8-bit and 5-bit builds, frames checked cycle by cycle
// against hand-written bit sequences listed in transmission order.
module tb_uart_tx_frame;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] baud_div;
  logic        parity_en, parity_odd, stop_bit;

  logic        tx_valid, tx_ready, tx_out, busy, tx_done;
  logic [7:0]  tx_data;
  logic        tx_valid5, tx_ready5, tx_out5, busy5, tx_done5;
  logic [4:0]  tx_data5;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_tx_frame #(.DATA_W(8), .DIV_W(16)) dut8 (
    .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .baud_div(baud_div), .parity_en(parity_en), .parity_odd(parity_odd), .stop_bit(stop_bit),
    .tx_out(tx_out), .busy(busy), .tx_done(tx_done)
  );

  uart_tx_frame #(.DATA_W(5), .DIV_W(16)) dut5 (
    .clk(clk), .reset(reset), .tx_valid(tx_valid5), .tx_data(tx_data5), .tx_ready(tx_ready5),
    .baud_div(baud_div), .parity_en(parity_en), .parity_odd(parity_odd), .stop_bit(stop_bit),
    .tx_out(tx_out5), .busy(busy5), .tx_done(tx_done5)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Handshake happens on the next edge; bits[n-1] is the first bit on the line.
  task automatic run_frame(input string tag, input logic [15:0] bits, input int n,
                           input int div, input bit hold, input bit scramble, input bit use5);
    int total;
    total = n * (div + 1);
    @(posedge clk); #1;
    if (!hold) begin
      tx_valid  = 1'b0;
      tx_valid5 = 1'b0;
    end
    for (int c = 0; c < total; c++) begin
      logic eb;
      eb = bits[n - 1 - (c / (div + 1))];
      check_eq({tag, " tx_out"}, use5 ? tx_out5 : tx_out, eb);
      check_eq({tag, " busy"}, use5 ? busy5 : busy, 1'b1);
      check_eq({tag, " tx_ready"}, use5 ? tx_ready5 : tx_ready, 1'b0);
      check_eq({tag, " tx_done"}, use5 ? tx_done5 : tx_done, 1'b0);
      if (scramble && c == 1) begin
        tx_data    = 8'hAA;
        baud_div   = 16'd6;
        parity_en  = 1'b1;
        parity_odd = 1'b1;
        stop_bit   = 1'b1;
      end
      if (scramble && c == total - 2) begin
        baud_div   = 16'(div);
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        stop_bit   = 1'b0;
      end
      @(posedge clk); #1;
    end
    check_eq({tag, " end tx_done"}, use5 ? tx_done5 : tx_done, 1'b1);
    check_eq({tag, " end busy"}, use5 ? busy5 : busy, 1'b0);
    check_eq({tag, " end tx_out"}, use5 ? tx_out5 : tx_out, 1'b1);
    check_eq({tag, " end tx_ready"}, use5 ? tx_ready5 : tx_ready, 1'b1);
  endtask

  task automatic setup(input logic [7:0] d, input logic [15:0] div, input logic pen,
                       input logic podd, input logic stp);
    tx_data    = d;
    baud_div   = div;
    parity_en  = pen;
    parity_odd = podd;
    stop_bit   = stp;
    tx_valid   = 1'b1;
  endtask

  task automatic idle_after(input string tag);
    @(posedge clk); #1;
    check_eq({tag, " done cleared"}, tx_done, 1'b0);
    check_eq({tag, " idle tx_out"}, tx_out, 1'b1);
  endtask

  initial begin
    reset = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; tx_valid5 = 1'b0; tx_data5 = 5'h00;
    baud_div = 16'd0; parity_en = 1'b0; parity_odd = 1'b0; stop_bit = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst tx_out", tx_out, 1'b1);
    check_eq("rst busy", busy, 1'b0);
    check_eq("rst tx_done", tx_done, 1'b0);
    check_eq("rst tx_ready", tx_ready, 1'b1);
    check_eq("rst5 tx_out", tx_out5, 1'b1);
    check_eq("rst5 tx_ready", tx_ready5, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    check_eq("post rst tx_ready", tx_ready, 1'b1);
    check_eq("post rst tx_out", tx_out, 1'b1);

    setup(8'hA5, 16'd3, 1'b0, 1'b0, 1'b0);
    run_frame("basic", 16'b0101001011, 10, 3, 1'b0, 1'b0, 1'b0);
    idle_after("basic");

    setup(8'hA5, 16'd3, 1'b1, 1'b0, 1'b0);
    run_frame("par_even", 16'b01010010101, 11, 3, 1'b0, 1'b0, 1'b0);
    idle_after("par_even");

    setup(8'hA5, 16'd3, 1'b1, 1'b1, 1'b0);
    run_frame("par_odd", 16'b01010010111, 11, 3, 1'b0, 1'b0, 1'b0);
    idle_after("par_odd");

    setup(8'h00, 16'd0, 1'b1, 1'b1, 1'b1);
    run_frame("two_stop", 16'b000000000111, 12, 0, 1'b0, 1'b0, 1'b0);
    idle_after("two_stop");

    setup(8'h55, 16'd1, 1'b0, 1'b0, 1'b0);
    run_frame("b2b_1", 16'b0101010101, 10, 1, 1'b1, 1'b1, 1'b0);
    run_frame("b2b_2", 16'b0010101011, 10, 1, 1'b0, 1'b0, 1'b0);
    idle_after("b2b_2");

    setup(8'h08, 16'd3, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    tx_valid = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    check_eq("mid data bit3", tx_out, 1'b1);
    check_eq("mid busy", busy, 1'b1);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check_eq("mid rst tx_out", tx_out, 1'b1);
    check_eq("mid rst busy", busy, 1'b0);
    check_eq("mid rst tx_ready", tx_ready, 1'b1);
    check_eq("mid rst tx_done", tx_done, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check_eq("after rst no done", tx_done, 1'b0);
      check_eq("after rst line high", tx_out, 1'b1);
    end

    setup(8'h3C, 16'd2, 1'b1, 1'b0, 1'b0);
    run_frame("after_rst", 16'b00011110001, 11, 2, 1'b0, 1'b0, 1'b0);
    idle_after("after_rst");

    baud_div = 16'd1; parity_en = 1'b1; parity_odd = 1'b0; stop_bit = 1'b0;
    tx_data5 = 5'h1F; tx_valid5 = 1'b1;
    run_frame("w5", 16'b01111111, 8, 1, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    check_eq("w5 done cleared", tx_done5, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
